datapath_multiciclo: RTL

- Next-generation MIPS-subset core: multicycle datapath with its own control FSM, replacing the single-cycle R-type datapath.
- Shares one external memory port for instructions and data, using a req/ready handshake that tolerates wait states.
- Adds reset, halt-on-illegal-opcode, a retired-instruction counter and a writeback strobe for the bench.

---
 rtl/datapath_multiciclo_pkg.sv | 74 +++++++
 rtl/datapath_multiciclo_regs.sv | 46 ++++
 rtl/datapath_multiciclo.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_multiciclo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_mc_pkg
// Description : Shared definitions for the multicycle MIPS-subset core:
//               opcode/funct codes, 4-bit ALU operation codes, FSM state
//               encoding and small decode helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_mc_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;

    // ALU operation codes, kept identical to the legacy ALU_Control encoding
    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    // True for every opcode/funct combination the core implements.
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
        logic ok;
        ok = 1'b0;
        case (op)
            c_OP_RTYPE: ok = (funct == c_FN_ADD) || (funct == c_FN_SUB) ||
                             (funct == c_FN_AND) || (funct == c_FN_OR)  ||
                             (funct == c_FN_SLT);
            c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_ADDI, c_OP_J: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] funct_to_aluop(input logic [5:0] funct);
        logic [3:0] op;
        case (funct)
            c_FN_AND: op = c_ALU_AND;
            c_FN_OR:  op = c_ALU_OR;
            c_FN_SUB: op = c_ALU_SUB;
            c_FN_SLT: op = c_ALU_SLT;
            default:  op = c_ALU_ADD;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/datapath_multiciclo_regs.sv
`default_nettype none
// ============================================================================
// Module      : banco_registros_rst
// Description : NUM_REGS x 32 register file, two asynchronous read ports,
//               one synchronous write port, asynchronous active-low clear.
//               Register 0 has no storage: it always reads 0 and ignores
//               writes.
// Ports       : clk_i, rst_ni         clock / async active-low clear
//               we_i, waddr_i, wdata_i write port
//               raddr1_i / rdata1_o    read port 1
//               raddr2_i / rdata2_o    read port 2
// Revision    : 1.0 - initial release
// ============================================================================
module banco_registros_rst #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [31:0]       rdata1_o,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [31:0]       rdata2_o
);

    // Entries 1..NUM_REGS-1 only; index 0 is synthesised as constant zero.
    logic [31:0] regs_q [1:NUM_REGS-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? 32'd0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? 32'd0 : regs_q[raddr2_i];

endmodule
`default_nettype wire

// File: rtl/datapath_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : datapath_multiciclo
// Description : Multicycle MIPS-subset core (add/sub/and/or/slt, lw, sw,
//               beq, addi, j) with an inline control FSM and ALU, sharing a
//               single req/ready memory port between fetch and data access.
//               Illegal instructions park the core in HALT until reset.
// Ports       : CLK, RST_N              clock / async active-low reset
//               mem_req/we/addr/wdata   memory request (held until ready)
//               mem_rdata, mem_ready    memory response
//               tr_salida_final         last value written to the reg file
//               wb_valid                one-cycle register-write strobe
//               pc_out, halted, retired status
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_multiciclo
    import datapath_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32,
    parameter int          NUM_REGS = 32   // power of two, 2..32
) (
    input  logic             CLK,
    input  logic             RST_N,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic [31:0]      tr_salida_final,
    output logic             wb_valid,
    output logic [31:0]      pc_out,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam int c_RA_W = $clog2(NUM_REGS);

    // ------------------------------------------------------------------
    // Architectural and pipeline-holding registers
    // ------------------------------------------------------------------
    state_t             state_q,   state_d;
    logic [31:0]        pc_q,      pc_d;
    logic [31:0]        ir_q,      ir_d;
    logic [31:0]        a_q,       a_d;
    logic [31:0]        b_q,       b_d;
    logic [31:0]        aluout_q,  aluout_d;
    logic [31:0]        mdr_q,     mdr_d;
    logic [31:0]        tr_q,      tr_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [31:0] w_sext;
    logic        w_unused_shamt;

    assign w_op    = ir_q[31:26];
    assign w_rs    = ir_q[25:21];
    assign w_rt    = ir_q[20:16];
    assign w_rd    = ir_q[15:11];
    assign w_funct = ir_q[5:0];
    assign w_sext  = sext16(ir_q[15:0]);
    // Shift amount field is not used by any supported instruction.
    assign w_unused_shamt = ^ir_q[10:6];

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic              w_rf_we;
    logic [c_RA_W-1:0] w_rf_waddr;
    logic [31:0]       w_rf_wdata;
    logic [31:0]       w_rf_rdata1;
    logic [31:0]       w_rf_rdata2;
    logic [c_RA_W-1:0] w_rs_idx;
    logic [c_RA_W-1:0] w_rt_idx;
    logic [c_RA_W-1:0] w_rd_idx;

    // Register indices are the instruction fields truncated to the file depth.
    assign w_rs_idx = w_rs[c_RA_W-1:0];
    assign w_rt_idx = w_rt[c_RA_W-1:0];
    assign w_rd_idx = w_rd[c_RA_W-1:0];

    banco_registros_rst #(
        .NUM_REGS (NUM_REGS)
    ) u_banco (
        .clk_i    (CLK),
        .rst_ni   (RST_N),
        .we_i     (w_rf_we),
        .waddr_i  (w_rf_waddr),
        .wdata_i  (w_rf_wdata),
        .raddr1_i (w_rs_idx),
        .rdata1_o (w_rf_rdata1),
        .raddr2_i (w_rt_idx),
        .rdata2_o (w_rf_rdata2)
    );

    // ------------------------------------------------------------------
    // ALU: R-type uses funct and B; every other EXEC use is A + sext(imm)
    // ------------------------------------------------------------------
    logic [3:0]  w_alu_op;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_res;

    assign w_alu_op = (w_op == c_OP_RTYPE) ? funct_to_aluop(w_funct) : c_ALU_ADD;
    assign w_alu_b  = (w_op == c_OP_RTYPE) ? b_q : w_sext;

    always_comb begin
        w_alu_res = '0;
        case (w_alu_op)
            c_ALU_AND: w_alu_res = a_q & w_alu_b;
            c_ALU_OR:  w_alu_res = a_q | w_alu_b;
            c_ALU_ADD: w_alu_res = a_q + w_alu_b;
            c_ALU_SUB: w_alu_res = a_q - w_alu_b;
            c_ALU_SLT: w_alu_res = {31'd0, ($signed(a_q) < $signed(w_alu_b))};
            default:   w_alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM: next-state and datapath register updates
    // ------------------------------------------------------------------
    logic        w_mem_req;
    logic        w_mem_we;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_wdata;
    logic [CNT_W-1:0] w_retired_inc;

    assign w_retired_inc = retired_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        aluout_d    = aluout_q;
        mdr_d       = mdr_q;
        tr_d        = tr_q;
        retired_d   = retired_q;
        w_rf_we     = 1'b0;
        w_rf_waddr  = '0;
        w_rf_wdata  = '0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;

        case (state_q)
            S_FETCH: begin
                w_mem_req  = 1'b1;
                w_mem_addr = pc_q;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                a_d      = w_rf_rdata1;
                b_d      = w_rf_rdata2;
                // Branch target computed speculatively; pc_q is already PC+4.
                aluout_d = pc_q + {w_sext[29:0], 2'b00};
                state_d  = is_legal(w_op, w_funct) ? S_EXEC : S_HALT;
            end

            S_EXEC: begin
                case (w_op)
                    c_OP_RTYPE, c_OP_ADDI: begin
                        aluout_d = w_alu_res;
                        state_d  = S_WB;
                    end
                    c_OP_LW, c_OP_SW: begin
                        aluout_d = w_alu_res;
                        state_d  = S_MEM;
                    end
                    c_OP_BEQ: begin
                        if (a_q == b_q) begin
                            pc_d = aluout_q;
                        end
                        retired_d = w_retired_inc;
                        state_d   = S_FETCH;
                    end
                    c_OP_J: begin
                        pc_d      = {pc_q[31:28], ir_q[25:0], 2'b00};
                        retired_d = w_retired_inc;
                        state_d   = S_FETCH;
                    end
                    default: state_d = S_HALT;
                endcase
            end

            S_MEM: begin
                w_mem_req  = 1'b1;
                w_mem_addr = aluout_q;
                if (w_op == c_OP_SW) begin
                    w_mem_we    = 1'b1;
                    w_mem_wdata = b_q;
                end
                if (mem_ready) begin
                    if (w_op == c_OP_SW) begin
                        retired_d = w_retired_inc;
                        state_d   = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                w_rf_we    = 1'b1;
                w_rf_waddr = (w_op == c_OP_RTYPE) ? w_rd_idx : w_rt_idx;
                w_rf_wdata = (w_op == c_OP_LW) ? mdr_q : aluout_q;
                tr_d       = w_rf_wdata;
                retired_d  = w_retired_inc;
                state_d    = S_FETCH;
            end

            S_HALT: state_d = S_HALT;

            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            aluout_q  <= '0;
            mdr_q     <= '0;
            tr_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            aluout_q  <= aluout_d;
            mdr_q     <= mdr_d;
            tr_q      <= tr_d;
            retired_q <= retired_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The state register resets to FETCH, so the memory port is
    // gated directly by RST_N: the request drops the instant reset asserts
    // and stays low (with the bus at zero) for the whole reset period.
    // ------------------------------------------------------------------
    assign mem_req         = w_mem_req & RST_N;
    assign mem_we          = w_mem_we  & RST_N;
    assign mem_addr        = RST_N ? w_mem_addr  : 32'd0;
    assign mem_wdata       = RST_N ? w_mem_wdata : 32'd0;
    assign tr_salida_final = tr_q;
    assign wb_valid        = (state_q == S_WB);
    assign pc_out          = pc_q;
    assign halted          = (state_q == S_HALT);
    assign retired         = retired_q;

endmodule
`default_nettype wire
